// File: rtl/rename_stage_nw_if.sv
// rename_stage_nw_if: decode->rename->dispatch bundle for the N-lane rename stage.
// Groups flush, the decode-side request (lanes, RAT read data, freelist heads),
// the RAT write port, the freelist pop count, the registered dispatch-side group
// and the performance counters. The master modport is the environment side and
// the slave modport is the rename stage.
interface rename_stage_nw_if #(
  parameter int WIDTH     = 2,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = $clog2(WIDTH + 1)
);
  logic                       flush;
  logic [WIDTH-1:0]           in_valid;
  logic                       in_ready;
  logic [WIDTH*LREG_W-1:0]    in_lrs1;
  logic [WIDTH*LREG_W-1:0]    in_lrs2;
  logic [WIDTH*LREG_W-1:0]    in_lrd;
  logic [WIDTH-1:0]           in_src1_is_reg;
  logic [WIDTH-1:0]           in_src2_is_reg;
  logic [WIDTH-1:0]           in_need_to_wb;
  logic [WIDTH*PAYLOAD_W-1:0] in_payload;
  logic [WIDTH*PREG_W-1:0]    rat_prs1;
  logic [WIDTH*PREG_W-1:0]    rat_prs2;
  logic [WIDTH*PREG_W-1:0]    rat_old_prd;
  logic [WIDTH-1:0]           rat_wr_valid;
  logic [WIDTH*LREG_W-1:0]    rat_wr_addr;
  logic [WIDTH*PREG_W-1:0]    rat_wr_data;
  logic [WIDTH*PREG_W-1:0]    fl_head;
  logic [CNT_W-1:0]           fl_avail;
  logic [CNT_W-1:0]           fl_pop_cnt;
  logic [WIDTH-1:0]           out_valid;
  logic                       out_ready;
  logic [WIDTH*PREG_W-1:0]    out_prs1;
  logic [WIDTH*PREG_W-1:0]    out_prs2;
  logic [WIDTH*PREG_W-1:0]    out_prd;
  logic [WIDTH*PREG_W-1:0]    out_old_prd;
  logic [WIDTH*LREG_W-1:0]    out_lrd;
  logic [WIDTH-1:0]           out_alloc;
  logic [WIDTH*PAYLOAD_W-1:0] out_payload;
  logic [31:0]                perf_fl_stall_cnt;
  logic [31:0]                perf_group_cnt;
  modport master (
    output flush, in_valid, in_lrs1, in_lrs2, in_lrd, in_src1_is_reg, in_src2_is_reg,
           in_need_to_wb, in_payload, rat_prs1, rat_prs2, rat_old_prd, fl_head, fl_avail,
           out_ready,
    input  in_ready, rat_wr_valid, rat_wr_addr, rat_wr_data, fl_pop_cnt, out_valid,
           out_prs1, out_prs2, out_prd, out_old_prd, out_lrd, out_alloc, out_payload,
           perf_fl_stall_cnt, perf_group_cnt
  );
  modport slave (
    input  flush, in_valid, in_lrs1, in_lrs2, in_lrd, in_src1_is_reg, in_src2_is_reg,
           in_need_to_wb, in_payload, rat_prs1, rat_prs2, rat_old_prd, fl_head, fl_avail,
           out_ready,
    output in_ready, rat_wr_valid, rat_wr_addr, rat_wr_data, fl_pop_cnt, out_valid,
           out_prs1, out_prs2, out_prd, out_old_prd, out_lrd, out_alloc, out_payload,
           perf_fl_stall_cnt, perf_group_cnt
  );
endinterface

// File: rtl/rename_stage_nw.sv
// rename_stage_nw: parametrised N-lane register-rename stage between decode and dispatch.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   io       rename_stage_nw_if.slave: flush, decode group in (valid/ready, lregs,
//            use flags, payload), same-cycle RAT read data, RAT write port,
//            freelist heads/avail/pop count, registered renamed group out
//            (valid/ready), performance counters.
// Optional feature: define RENAME_PERF_CNT_EN to build the saturating freelist-stall
// and accepted-group counters; otherwise both counter ports read 0.
// A group is accepted whole or not at all: it stalls while the output register is
// occupied and not draining, while the freelist cannot cover every allocating lane,
// or during flush.
module rename_stage_nw #(
  parameter int WIDTH     = 2,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input logic             clock,
  input logic             reset_n,
  rename_stage_nw_if.slave io
);
  logic [WIDTH-1:0]           alloc;
  logic [WIDTH-1:0]           wr_keep;
  logic [CNT_W-1:0]           need;
  logic [WIDTH*PREG_W-1:0]    prd;
  logic [WIDTH*PREG_W-1:0]    prs1;
  logic [WIDTH*PREG_W-1:0]    prs2;
  logic [WIDTH*PREG_W-1:0]    old_prd;
  logic                       out_free;
  logic                       fl_ok;
  logic                       ready;
  logic                       accept;
  logic [WIDTH-1:0]           ov_q;
  logic [WIDTH*PREG_W-1:0]    prs1_q;
  logic [WIDTH*PREG_W-1:0]    prs2_q;
  logic [WIDTH*PREG_W-1:0]    prd_q;
  logic [WIDTH*PREG_W-1:0]    old_prd_q;
  logic [WIDTH*LREG_W-1:0]    lrd_q;
  logic [WIDTH-1:0]           alloc_q;
  logic [WIDTH*PAYLOAD_W-1:0] payload_q;
  // x0 is hard-wired, so it never consumes a preg nor creates a dependency
  always_comb begin
    alloc = '0;
    for (int k = 0; k < WIDTH; k++)
      alloc[k] = io.in_valid[k] & io.in_need_to_wb[k] & (io.in_lrd[k*LREG_W +: LREG_W] != '0);
  end
  // Each allocating lane takes the freelist slot indexed by the number of older allocators
  always_comb begin
    need = '0;
    prd  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc[k])
        prd[k*PREG_W +: PREG_W] = io.fl_head[int'(need)*PREG_W +: PREG_W];
      need = need + CNT_W'(alloc[k]);
    end
  end
  // Scanning older lanes oldest-first lets the youngest matching writer win
  always_comb begin
    prs1    = io.rat_prs1;
    prs2    = io.rat_prs2;
    old_prd = io.rat_old_prd;
    for (int j = 1; j < WIDTH; j++)
      for (int i = 0; i < j; i++)
        if (alloc[i]) begin
          if (io.in_src1_is_reg[j] && io.in_lrd[i*LREG_W +: LREG_W] == io.in_lrs1[j*LREG_W +: LREG_W])
            prs1[j*PREG_W +: PREG_W] = prd[i*PREG_W +: PREG_W];
          if (io.in_src2_is_reg[j] && io.in_lrd[i*LREG_W +: LREG_W] == io.in_lrs2[j*LREG_W +: LREG_W])
            prs2[j*PREG_W +: PREG_W] = prd[i*PREG_W +: PREG_W];
          if (io.in_lrd[i*LREG_W +: LREG_W] == io.in_lrd[j*LREG_W +: LREG_W])
            old_prd[j*PREG_W +: PREG_W] = prd[i*PREG_W +: PREG_W];
        end
  end
  // Only the youngest writer of a logical register updates the RAT
  always_comb begin
    wr_keep = alloc;
    for (int j = 0; j < WIDTH - 1; j++)
      for (int i = j + 1; i < WIDTH; i++)
        if (alloc[i] && io.in_lrd[i*LREG_W +: LREG_W] == io.in_lrd[j*LREG_W +: LREG_W])
          wr_keep[j] = 1'b0;
  end
  assign out_free        = ~|ov_q | io.out_ready;
  assign fl_ok           = io.fl_avail >= need;
  assign ready           = reset_n & ~io.flush & out_free & fl_ok;
  assign accept          = ready & |io.in_valid;
  assign io.in_ready     = ready;
  assign io.rat_wr_valid = accept ? wr_keep : '0;
  assign io.rat_wr_addr  = io.in_lrd;
  assign io.rat_wr_data  = prd;
  assign io.fl_pop_cnt   = accept ? need : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ov_q      <= '0;
      prs1_q    <= '0;
      prs2_q    <= '0;
      prd_q     <= '0;
      old_prd_q <= '0;
      lrd_q     <= '0;
      alloc_q   <= '0;
      payload_q <= '0;
    end else if (io.flush) begin
      ov_q <= '0;
    end else if (accept) begin
      ov_q      <= io.in_valid;
      prs1_q    <= prs1;
      prs2_q    <= prs2;
      prd_q     <= prd;
      old_prd_q <= old_prd;
      lrd_q     <= io.in_lrd;
      alloc_q   <= alloc;
      payload_q <= io.in_payload;
    end else if (io.out_ready) begin
      ov_q <= '0;
    end
  end
  assign io.out_valid   = ov_q;
  assign io.out_prs1    = prs1_q;
  assign io.out_prs2    = prs2_q;
  assign io.out_prd     = prd_q;
  assign io.out_old_prd = old_prd_q;
  assign io.out_lrd     = lrd_q;
  assign io.out_alloc   = alloc_q;
  assign io.out_payload = payload_q;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] group_q;
  logic        stall;
  // Counts cycles where only the freelist holds a real group back
  assign stall = |io.in_valid & ~io.flush & out_free & ~fl_ok;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      group_q <= '0;
    end else begin
      if (stall && ~&stall_q) stall_q <= stall_q + 32'd1;
      if (accept && ~&group_q) group_q <= group_q + 32'd1;
    end
  end
  assign io.perf_fl_stall_cnt = stall_q;
  assign io.perf_group_cnt    = group_q;
`else
  assign io.perf_fl_stall_cnt = '0;
  assign io.perf_group_cnt    = '0;
`endif
endmodule

// File: tb/tb_rename_stage_nw.sv
// tb_rename_stage_nw: scoreboard bench for rename_stage_nw (WIDTH=4).
module tb_rename_stage_nw;
  localparam int WIDTH     = 4;
  localparam int LREG_W    = 5;
  localparam int PREG_W    = 6;
  localparam int PAYLOAD_W = 160;
  localparam int CNT_W     = $clog2(WIDTH + 1);
  localparam int VW        = WIDTH * PAYLOAD_W;
  localparam int NL        = 2 ** LREG_W;
  typedef struct {
    logic [WIDTH-1:0]        valid;
    logic [WIDTH-1:0]        alloc;
    logic [WIDTH-1:0]        wr;
    logic [WIDTH*PREG_W-1:0] prs1;
    logic [WIDTH*PREG_W-1:0] prs2;
    logic [WIDTH*PREG_W-1:0] prd;
    logic [WIDTH*PREG_W-1:0] oldp;
    logic [WIDTH*LREG_W-1:0] lrd;
    logic [VW-1:0]           pay;
  } grp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  rename_stage_nw_if #(.WIDTH(WIDTH), .LREG_W(LREG_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) io ();
  rename_stage_nw #(.WIDTH(WIDTH), .LREG_W(LREG_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
    .clock(clk),
    .reset_n(reset_n),
    .io(io)
  );
  int n_chk = 0;
  int n_fail = 0;
  grp_t q[$];
  bit mvalid = 0;
  bit acc_last = 0;
  int st_cnt = 0;
  int gr_cnt = 0;
  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Sequential reference: walk lanes oldest-first keeping an in-group rename map
  task automatic model(output grp_t g, output int need);
    logic [PREG_W-1:0] mp [NL];
    bit hit [NL];
    bit seen [NL];
    logic [LREG_W-1:0] r1, r2, rd;
    int nxt;
    nxt = 0;
    g = '{default: '0};
    for (int i = 0; i < NL; i++) begin
      hit[i] = 0;
      seen[i] = 0;
      mp[i] = '0;
    end
    for (int j = 0; j < WIDTH; j++) begin
      r1 = io.in_lrs1[j*LREG_W +: LREG_W];
      r2 = io.in_lrs2[j*LREG_W +: LREG_W];
      rd = io.in_lrd[j*LREG_W +: LREG_W];
      g.prs1[j*PREG_W +: PREG_W] = (io.in_src1_is_reg[j] && hit[r1]) ? mp[r1] : io.rat_prs1[j*PREG_W +: PREG_W];
      g.prs2[j*PREG_W +: PREG_W] = (io.in_src2_is_reg[j] && hit[r2]) ? mp[r2] : io.rat_prs2[j*PREG_W +: PREG_W];
      g.oldp[j*PREG_W +: PREG_W] = hit[rd] ? mp[rd] : io.rat_old_prd[j*PREG_W +: PREG_W];
      g.alloc[j] = io.in_valid[j] && io.in_need_to_wb[j] && rd != 0;
      if (g.alloc[j]) begin
        g.prd[j*PREG_W +: PREG_W] = io.fl_head[nxt*PREG_W +: PREG_W];
        mp[rd] = io.fl_head[nxt*PREG_W +: PREG_W];
        hit[rd] = 1;
        nxt++;
      end
    end
    for (int j = WIDTH - 1; j >= 0; j--) begin
      rd = io.in_lrd[j*LREG_W +: LREG_W];
      if (g.alloc[j] && !seen[rd]) begin
        g.wr[j] = 1'b1;
        seen[rd] = 1;
      end
    end
    g.valid = io.in_valid;
    g.lrd = io.in_lrd;
    g.pay = io.in_payload;
    need = nxt;
  endtask
  grp_t mg;
  int mneed;
  bit mfree, macc;
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      mvalid = 0;
      acc_last = 0;
      st_cnt = 0;
      gr_cnt = 0;
      check("rst_in_ready", VW'(io.in_ready), '0);
      check("rst_out_valid", VW'(io.out_valid), '0);
      check("rst_pop", VW'(io.fl_pop_cnt), '0);
      check("rst_rat_wv", VW'(io.rat_wr_valid), '0);
      check("rst_out_prd", VW'(io.out_prd), '0);
      check("rst_out_payload", io.out_payload, '0);
      check("rst_perf_stall", VW'(io.perf_fl_stall_cnt), '0);
      check("rst_perf_group", VW'(io.perf_group_cnt), '0);
    end else begin
      model(mg, mneed);
      mfree = !mvalid || io.out_ready;
      macc = !io.flush && mfree && (int'(io.fl_avail) >= mneed) && (io.in_valid != '0);
      check("in_ready", VW'(io.in_ready), VW'(!io.flush && mfree && (int'(io.fl_avail) >= mneed)));
      check("fl_pop_cnt", VW'(io.fl_pop_cnt), macc ? VW'(mneed) : '0);
      check("rat_wr_valid", VW'(io.rat_wr_valid), macc ? VW'(mg.wr) : '0);
      for (int k = 0; k < WIDTH; k++)
        if (macc && mg.wr[k]) begin
          check($sformatf("rat_wr_addr%0d", k), VW'(io.rat_wr_addr[k*LREG_W +: LREG_W]), VW'(mg.lrd[k*LREG_W +: LREG_W]));
          check($sformatf("rat_wr_data%0d", k), VW'(io.rat_wr_data[k*PREG_W +: PREG_W]), VW'(mg.prd[k*PREG_W +: PREG_W]));
        end
      check("out_valid", VW'(io.out_valid), mvalid ? VW'(q[0].valid) : '0);
      if (mvalid) begin
        check("out_prs1", VW'(io.out_prs1), VW'(q[0].prs1));
        check("out_prs2", VW'(io.out_prs2), VW'(q[0].prs2));
        check("out_prd", VW'(io.out_prd), VW'(q[0].prd));
        check("out_old_prd", VW'(io.out_old_prd), VW'(q[0].oldp));
        check("out_lrd", VW'(io.out_lrd), VW'(q[0].lrd));
        check("out_alloc", VW'(io.out_alloc), VW'(q[0].alloc));
        check("out_payload", io.out_payload, q[0].pay);
      end
`ifdef RENAME_PERF_CNT_EN
      check("perf_stall", VW'(io.perf_fl_stall_cnt), VW'(st_cnt));
      check("perf_group", VW'(io.perf_group_cnt), VW'(gr_cnt));
`else
      check("perf_stall", VW'(io.perf_fl_stall_cnt), '0);
      check("perf_group", VW'(io.perf_group_cnt), '0);
`endif
      if ((io.in_valid != '0) && !io.flush && mfree && int'(io.fl_avail) < mneed) st_cnt++;
      if (macc) gr_cnt++;
      if (io.flush) begin
        if (mvalid) void'(q.pop_front());
        mvalid = 0;
      end else if (macc) begin
        if (mvalid) void'(q.pop_front());
        q.push_back(mg);
        mvalid = 1;
      end else if (mvalid && io.out_ready) begin
        void'(q.pop_front());
        mvalid = 0;
      end
      acc_last = macc;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    io.flush = 0;
    io.in_valid = '0;
    io.in_lrs1 = '0;
    io.in_lrs2 = '0;
    io.in_lrd = '0;
    io.in_src1_is_reg = '0;
    io.in_src2_is_reg = '0;
    io.in_need_to_wb = '0;
    io.in_payload = '0;
    io.rat_prs1 = '0;
    io.rat_prs2 = '0;
    io.rat_old_prd = '0;
  endtask
  task automatic lane(input int k, input bit v, input int r1, input int r2, input int rd, input bit wb,
                      input int p1, input int p2, input int op);
    io.in_valid[k] = v;
    io.in_lrs1[k*LREG_W +: LREG_W] = LREG_W'(r1);
    io.in_lrs2[k*LREG_W +: LREG_W] = LREG_W'(r2);
    io.in_lrd[k*LREG_W +: LREG_W] = LREG_W'(rd);
    io.in_need_to_wb[k] = wb;
    io.in_src1_is_reg[k] = 1'b1;
    io.in_src2_is_reg[k] = 1'b1;
    io.rat_prs1[k*PREG_W +: PREG_W] = PREG_W'(p1);
    io.rat_prs2[k*PREG_W +: PREG_W] = PREG_W'(p2);
    io.rat_old_prd[k*PREG_W +: PREG_W] = PREG_W'(op);
    io.in_payload[k*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic fl_set(input int avail, input int base);
    io.fl_avail = CNT_W'(avail);
    for (int k = 0; k < WIDTH; k++) io.fl_head[k*PREG_W +: PREG_W] = PREG_W'(base + k);
  endtask
  task automatic rand_group();
    int n;
    clr();
    n = $urandom_range(0, WIDTH);
    for (int k = 0; k < WIDTH; k++)
      lane(k, k < n, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    io.in_src1_is_reg = WIDTH'($urandom);
    io.in_src2_is_reg = WIDTH'($urandom);
  endtask
  initial begin
    clr();
    io.out_ready = 1;
    fl_set(0, 0);
    tick(2);
    reset_n = 1;
    // two-lane RAW: lane1 reads lane0's new mapping
    clr();
    lane(0, 1, 1, 2, 5, 1, 20, 21, 22);
    lane(1, 1, 5, 3, 9, 1, 23, 24, 25);
    fl_set(2, 11);
    #1;
    check("t1_pop", VW'(io.fl_pop_cnt), VW'(2));
    tick(1);
    clr();
    check("t1_prd", VW'(io.out_prd[2*PREG_W-1:0]), VW'({6'd12, 6'd11}));
    check("t1_prs1_l1", VW'(io.out_prs1[PREG_W +: PREG_W]), VW'(11));
    // WAW across lanes 0 and 2, lane3 reads the youngest writer
    lane(0, 1, 1, 1, 7, 1, 1, 1, 3);
    lane(1, 1, 2, 2, 8, 0, 2, 2, 3);
    lane(2, 1, 3, 3, 7, 1, 4, 4, 3);
    lane(3, 1, 7, 4, 9, 0, 5, 5, 3);
    fl_set(4, 30);
    #1;
    check("t2_rat_wv", VW'(io.rat_wr_valid), VW'(4'b0100));
    check("t2_pop", VW'(io.fl_pop_cnt), VW'(2));
    tick(1);
    clr();
    check("t2_old_l2", VW'(io.out_old_prd[2*PREG_W +: PREG_W]), VW'(30));
    check("t2_prs1_l3", VW'(io.out_prs1[3*PREG_W +: PREG_W]), VW'(31));
    check("t2_old_l0", VW'(io.out_old_prd[0 +: PREG_W]), VW'(3));
    // freelist short stalls the whole group until it fills
    lane(0, 1, 1, 2, 3, 1, 6, 7, 8);
    lane(1, 1, 3, 2, 4, 1, 9, 10, 11);
    fl_set(1, 40);
    #1;
    check("t3_ready_short", VW'(io.in_ready), '0);
    check("t3_pop_short", VW'(io.fl_pop_cnt), '0);
    check("t3_wv_short", VW'(io.rat_wr_valid), '0);
    tick(2);
    fl_set(2, 40);
    #1;
    check("t3_ready_ok", VW'(io.in_ready), VW'(1));
    tick(1);
    clr();
    // dispatch back-pressure holds the output, then back-to-back reload
    io.out_ready = 0;
    lane(0, 1, 4, 5, 6, 1, 12, 13, 14);
    fl_set(4, 50);
    tick(1);
    clr();
    lane(0, 1, 6, 6, 10, 1, 15, 16, 17);
    lane(1, 1, 10, 6, 11, 1, 18, 19, 20);
    lane(2, 1, 11, 10, 0, 1, 21, 22, 23);
    for (int c = 0; c < 3; c++) begin
      check("t4_ready_held", VW'(io.in_ready), '0);
      tick(1);
    end
    io.out_ready = 1;
    #1;
    check("t4_ready_drain", VW'(io.in_ready), VW'(1));
    tick(1);
    clr();
    check("t4_reload_valid", VW'(io.out_valid), VW'(4'b0111));
    // flush with held output and a pending group
    io.out_ready = 0;
    lane(0, 1, 1, 1, 2, 1, 1, 1, 1);
    tick(1);
    clr();
    lane(0, 1, 2, 2, 3, 1, 2, 2, 2);
    io.flush = 1;
    #1;
    check("t5_ready", VW'(io.in_ready), '0);
    check("t5_pop", VW'(io.fl_pop_cnt), '0);
    check("t5_wv", VW'(io.rat_wr_valid), '0);
    tick(1);
    clr();
    check("t5_out_valid", VW'(io.out_valid), '0);
    io.out_ready = 1;
    // x0 destination: no allocation even with an empty freelist
    lane(0, 1, 0, 0, 0, 1, 9, 9, 9);
    fl_set(0, 60);
    #1;
    check("t6_ready", VW'(io.in_ready), VW'(1));
    check("t6_pop", VW'(io.fl_pop_cnt), '0);
    check("t6_wv", VW'(io.rat_wr_valid), '0);
    tick(1);
    clr();
    check("t6_alloc", VW'(io.out_alloc), '0);
    check("t6_prd", VW'(io.out_prd), '0);
    check("t6_valid", VW'(io.out_valid), VW'(1));
    // asynchronous reset in the middle of a stall
    io.out_ready = 0;
    lane(0, 1, 1, 2, 3, 1, 1, 2, 3);
    fl_set(1, 20);
    tick(1);
    clr();
    lane(0, 1, 1, 2, 3, 1, 1, 2, 3);
    lane(1, 1, 1, 2, 4, 1, 1, 2, 3);
    fl_set(0, 20);
    tick(2);
    #2;
    reset_n = 0;
    #1;
    check("t6_async_valid", VW'(io.out_valid), '0);
    check("t6_async_ready", VW'(io.in_ready), '0);
    tick(1);
    reset_n = 1;
    io.out_ready = 1;
    clr();
    tick(1);
    // random traffic: upstream holds a stalled group, freelist/back-pressure/flush vary
    rand_group();
    for (int c = 0; c < 400; c++) begin
      fl_set($urandom_range(0, WIDTH), $urandom_range(1, 56));
      io.out_ready = $urandom_range(0, 9) < 7;
      io.flush = $urandom_range(0, 19) == 0;
      tick(1);
      if (acc_last || io.flush || io.in_valid == '0) rand_group();
    end
    clr();
    io.out_ready = 1;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rename_stage_nw.md
Name: rename_stage_nw

Overview:
- Parametrised N-lane register-rename stage; successor to the fixed 2-wide combinational renamer.
- Sits between decode and dispatch.
- Reads RAT lookups for each lane and allocates destination pregs from a multi-head freelist.
- Resolves intra-group RAW/WAW dependencies for any WIDTH, writes the RAT, and presents the renamed group through a registered valid/ready output stage with flush.

Parameters:
- WIDTH, 2, number of rename lanes per group (1..8).
- LREG_W, 5, logical register index width.
- PREG_W, 6, physical register index width.
- PAYLOAD_W, 160, opaque per-lane decode payload (instr, pc, imm, type flags), passed through unchanged.
- CNT_W, $clog2(WIDTH+1), width of freelist count fields.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  redirect; kills the held group and blocks acceptance this cycle.
- in_valid  in  WIDTH  per-lane valid; lanes contiguous from lane 0.
- in_ready  out  1  whole group accepted when in_ready & |in_valid.
- in_lrs1, in_lrs2, in_lrd  in  WIDTH*LREG_W  logical source and destination registers.
- in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  WIDTH  source/destination use flags.
- in_payload  in  WIDTH*PAYLOAD_W  passthrough payload.
- rat_prs1, rat_prs2, rat_old_prd  in  WIDTH*PREG_W  same-cycle RAT read data for in_lrs1, in_lrs2, in_lrd.
- rat_wr_valid  out  WIDTH  RAT write enables.
- rat_wr_addr  out  WIDTH*LREG_W  RAT write addresses.
- rat_wr_data  out  WIDTH*PREG_W  RAT write data.
- fl_head  in  WIDTH*PREG_W  next WIDTH free pregs, oldest in slot 0.
- fl_avail  in  CNT_W  number of valid fl_head slots.
- fl_pop_cnt  out  CNT_W  pregs consumed this cycle.
- out_valid  out  WIDTH  registered lane valids.
- out_ready  in  1  dispatch accepts the whole group.
- out_prs1, out_prs2, out_prd, out_old_prd  out  WIDTH*PREG_W  renamed operands.
- out_lrd  out  WIDTH*LREG_W  logical destination.
- out_alloc  out  WIDTH  lane owns a new preg.
- out_payload  out  WIDTH*PAYLOAD_W  registered payload.
- perf_fl_stall_cnt, perf_group_cnt  out  32 each  performance counters.

Behaviour:
- alloc[k] = in_valid[k] & in_need_to_wb[k] & (in_lrd[k] != 0).
  - x0 never allocates, never writes the RAT.
  - x0 sources are never bypassed.
- need = popcount(alloc).
- Lane k allocation: prd[k] = fl_head[popcount(alloc[k-1:0])]. Non-alloc lanes output prd = 0.
- Source bypass: lane j source s (with s_is_reg set) takes prd of the youngest lane i<j with alloc[i] & in_lrd[i]==lrs_s[j]; otherwise it takes rat_prs_s[j].
  - Sources with is_reg clear pass rat data unchanged.
- old_prd[j]: prd of the youngest older lane allocating the same lrd; otherwise rat_old_prd[j].
- RAT write for lane k = alloc[k] & accept & no younger lane in the group allocating the same lrd. Only the youngest WAW writer writes.
- in_ready = !flush & (!(|out_valid) | out_ready) & (fl_avail >= need).
  - in_ready is combinational on in_need_to_wb/in_lrd/in_valid.
  - Upstream must hold inputs stable while in_valid & !in_ready.
- accept = in_ready & |in_valid. In the accept cycle only:
  - rat_wr_valid is asserted.
  - fl_pop_cnt = need.
  - Otherwise both are 0.
- Output register loads on accept; latency 1 cycle from input accept to out_valid.
- Output holds stable while out_valid & !out_ready.
- out_valid clears on out_ready when there is no new accept.
- Back-to-back groups are accepted at full throughput when out_ready = 1.
- Flush: out_valid clears at the next edge regardless of out_ready. No accept, no RAT write, no pop in the flush cycle.
- Freelist short (fl_avail < need): the group stalls whole. The group is never split.
- need = 0 groups accept even when fl_avail = 0.
- Reset (async, reset_n low): out_valid = 0; all out_* data = 0; perf counters = 0. Combinational outputs are forced inactive while in reset.

Optional Feature:
- Macro: RENAME_PERF_CNT_EN.
- Defined:
  - perf_fl_stall_cnt increments each cycle |in_valid & !flush & output-free & fl_avail < need.
  - perf_group_cnt increments per accept.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- WIDTH=2, lane0 lrd=5 alloc, lane1 lrs1=5, fl_head={12,11}, fl_avail=2 -> next cycle out_prd={12,11}, out_prs1[1]=11, fl_pop_cnt=2 in accept cycle.
- WIDTH=4, lanes 0,2 write lrd=7, lane3 reads 7, rat_old_prd[7]=3 -> out_old_prd[2]=lane0 prd, out_prs1[3]=lane2 prd, rat_wr_valid=4'b0100.
- fl_avail=1 with need=2 -> in_ready=0, no pop, no RAT write; fl_avail rises to 2 -> accept same cycle.
- out_valid=1, out_ready=0 for 3 cycles -> outputs stable, in_ready=0; then out_ready=1 with new group -> back-to-back load.
- flush while output held and new group pending -> out_valid=0 next cycle, fl_pop_cnt=0, rat_wr_valid=0.
- lrd=0 with need_to_wb=1 -> out_alloc=0, no pop, no RAT write, out_prd=0; reset_n asserted mid-stall -> out_valid=0 immediately.
